// File: rtl/output_bcd_display.sv
// ---------------------------------------------------------------------------
// output_bcd_display
//   Captures each value written to the CPU output register and converts it
//   from 8-bit binary to three BCD digits with an iterative shift-add-3
//   engine (one bit per cycle). Drives a time-multiplexed three-digit
//   seven-segment display with leading-zero blanking.
//
// Ports:
//   clk       in   system clock, rising edge
//   rst       in   asynchronous reset, active low
//   load      in   new-value strobe from the top level
//   dataIn    in   [7:0] unsigned value to convert
//   busy      out  high while a conversion is running
//   dataValid out  sticky flag: at least one conversion has completed
//   bcdOut    out  [11:0] {hundreds, tens, ones} of the last finished result
//   seg       out  [6:0] segments {g,f,e,d,c,b,a} for the selected digit
//   digitSel  out  [2:0] one-hot digit enable (bit0 ones .. bit2 hundreds)
// ---------------------------------------------------------------------------
module output_bcd_display #(
    parameter int unsigned REFRESH_DIV  = 1024,
    parameter bit          COMMON_ANODE = 1'b0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        load,
    input  logic [7:0]  dataIn,
    output logic        busy,
    output logic        dataValid,
    output logic [11:0] bcdOut,
    output logic [6:0]  seg,
    output logic [2:0]  digitSel
);

    localparam logic [0:0]  IDLE         = 1'b0;
    localparam logic [0:0]  CONVERT      = 1'b1;
    localparam logic [15:0] REFRESH_LAST = 16'(REFRESH_DIV - 1);

    logic [0:0]  state;
    logic [7:0]  shiftReg;
    logic [11:0] scratch;
    logic [2:0]  iterCnt;
    logic        pending;
    logic [7:0]  pendData;
    logic [11:0] adjusted;
    logic [11:0] nextScratch;
    logic        lastIter;

    logic [15:0] refCnt;
    logic [1:0]  digitIdx;
    logic [3:0]  digitVal;
    logic        blank;
    logic [6:0]  segNext;
    logic [2:0]  selNext;

    assign busy     = (state == CONVERT);
    assign lastIter = (iterCnt == 3'd7);

    // Add-3 correction on every nibble >= 5, then shift in the next bit.
    always_comb begin
        adjusted = scratch;
        for (int unsigned i = 0; i < 3; i++) begin
            if (scratch[4*i +: 4] >= 4'd5)
                adjusted[4*i +: 4] = scratch[4*i +: 4] + 4'd3;
        end
        nextScratch = {adjusted[10:0], shiftReg[7]};
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            shiftReg  <= '0;
            scratch   <= '0;
            iterCnt   <= '0;
            pending   <= 1'b0;
            pendData  <= '0;
            dataValid <= 1'b0;
            bcdOut    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (load) begin
                        shiftReg <= dataIn;
                        scratch  <= '0;
                        iterCnt  <= '0;
                        state    <= CONVERT;
                    end
                end
                default: begin
                    scratch  <= nextScratch;
                    shiftReg <= {shiftReg[6:0], 1'b0};
                    iterCnt  <= iterCnt + 3'd1;
                    if (lastIter) begin
                        bcdOut    <= nextScratch;
                        dataValid <= 1'b1;
                        scratch   <= '0;
                        iterCnt   <= '0;
                        // Pending value has priority; a simultaneous load
                        // refills the one-entry buffer.
                        if (pending) begin
                            shiftReg <= pendData;
                            pending  <= load;
                            if (load)
                                pendData <= dataIn;
                        end else if (load) begin
                            shiftReg <= dataIn;
                        end else begin
                            state <= IDLE;
                        end
                    end else if (load) begin
                        pendData <= dataIn;
                        pending  <= 1'b1;
                    end
                end
            endcase
        end
    end

    always_comb begin
        case (digitIdx)
            2'd0:    digitVal = bcdOut[3:0];
            2'd1:    digitVal = bcdOut[7:4];
            default: digitVal = bcdOut[11:8];
        endcase

        case (digitIdx)
            2'd0:    selNext = 3'b001;
            2'd1:    selNext = 3'b010;
            default: selNext = 3'b100;
        endcase

        // Leading-zero blanking; ones always lit once a result exists.
        blank = !dataValid
             || (digitIdx == 2'd2 && bcdOut[11:8] == 4'd0)
             || (digitIdx == 2'd1 && bcdOut[11:8] == 4'd0 && bcdOut[7:4] == 4'd0);

        case (digitVal)
            4'd0:    segNext = 7'b0111111;
            4'd1:    segNext = 7'b0000110;
            4'd2:    segNext = 7'b1011011;
            4'd3:    segNext = 7'b1001111;
            4'd4:    segNext = 7'b1100110;
            4'd5:    segNext = 7'b1101101;
            4'd6:    segNext = 7'b1111101;
            4'd7:    segNext = 7'b0000111;
            4'd8:    segNext = 7'b1111111;
            4'd9:    segNext = 7'b1101111;
            default: segNext = 7'b0000000;
        endcase
        if (blank)
            segNext = 7'b0000000;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            refCnt   <= '0;
            digitIdx <= '0;
            seg      <= {7{COMMON_ANODE}};
            digitSel <= 3'b001 ^ {3{COMMON_ANODE}};
        end else begin
            if (refCnt == REFRESH_LAST) begin
                refCnt   <= '0;
                digitIdx <= (digitIdx == 2'd2) ? 2'd0 : digitIdx + 2'd1;
            end else begin
                refCnt <= refCnt + 16'd1;
            end
            seg      <= segNext ^ {7{COMMON_ANODE}};
            digitSel <= selNext ^ {3{COMMON_ANODE}};
        end
    end

endmodule

// File: tb/tb_output_bcd_display.sv
// ---------------------------------------------------------------------------
// tb_output_bcd_display
//   Directed bench for output_bcd_display (REFRESH_DIV = 4). Expected BCD
//   results are queued when a load is driven and popped at the completion
//   edge. A second instance with COMMON_ANODE = 1 shares all inputs.
// ---------------------------------------------------------------------------
module tb_output_bcd_display;

    localparam int unsigned RD = 4;

    logic        clk;
    logic        rst;
    logic        load;
    logic [7:0]  dataIn;
    logic        busy, dataValid;
    logic [11:0] bcdOut;
    logic [6:0]  seg;
    logic [2:0]  digitSel;
    logic        caBusy, caDataValid;
    logic [11:0] caBcdOut;
    logic [6:0]  caSeg;
    logic [2:0]  caDigitSel;

    int unsigned total = 0;
    int unsigned bad   = 0;
    logic [11:0] expQ[$];

    output_bcd_display #(.REFRESH_DIV(RD), .COMMON_ANODE(1'b0)) dut (
        .clk(clk), .rst(rst), .load(load), .dataIn(dataIn),
        .busy(busy), .dataValid(dataValid), .bcdOut(bcdOut),
        .seg(seg), .digitSel(digitSel)
    );

    output_bcd_display #(.REFRESH_DIV(RD), .COMMON_ANODE(1'b1)) dutCa (
        .clk(clk), .rst(rst), .load(load), .dataIn(dataIn),
        .busy(caBusy), .dataValid(caDataValid), .bcdOut(caBcdOut),
        .seg(caSeg), .digitSel(caDigitSel)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    function automatic logic [6:0] segPat(input logic [3:0] d);
        case (d)
            4'd0: return 7'b0111111;
            4'd1: return 7'b0000110;
            4'd2: return 7'b1011011;
            4'd3: return 7'b1001111;
            4'd4: return 7'b1100110;
            4'd5: return 7'b1101101;
            4'd6: return 7'b1111101;
            4'd7: return 7'b0000111;
            4'd8: return 7'b1111111;
            4'd9: return 7'b1101111;
            default: return 7'b0000000;
        endcase
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // n edges, busy checked after each
    task automatic runSteps(input int n, input logic expBusy, input string tag);
        for (int i = 0; i < n; i++) begin
            step();
            check(tag, {31'd0, busy}, {31'd0, expBusy});
        end
    endtask

    task automatic popCheck(input string tag);
        logic [11:0] e;
        if (expQ.size() == 0) begin
            check({tag, "_queue_empty"}, 32'd1, 32'd0);
        end else begin
            e = expQ.pop_front();
            check(tag, {20'd0, bcdOut}, {20'd0, e});
            check({tag, "_valid"}, {31'd0, dataValid}, 32'd1);
        end
    endtask

    task automatic startLoad(input logic [7:0] v, input logic push, input logic [11:0] exp);
        load   = 1'b1;
        dataIn = v;
        if (push) expQ.push_back(exp);
    endtask

    task automatic waitSel(input logic [2:0] target, input string tag, output logic found);
        found = 1'b0;
        for (int i = 0; i < 3 * RD + 4; i++) begin
            if (digitSel === target) begin
                found = 1'b1;
                break;
            end
            step();
        end
        if (!found) check({tag, "_timeout"}, {29'd0, digitSel}, {29'd0, target});
    endtask

    task automatic checkDigit(input logic [2:0] target, input logic [6:0] expSeg, input string tag);
        logic found;
        waitSel(target, tag, found);
        if (found) begin
            check(tag, {25'd0, seg}, {25'd0, expSeg});
            check({tag, "_ca_seg"}, {25'd0, caSeg}, {25'd0, ~expSeg});
            check({tag, "_ca_sel"}, {29'd0, caDigitSel}, {29'd0, ~target});
        end
    endtask

    initial begin
        int n;
        logic found;
        rst = 1'b0; load = 1'b0; dataIn = '0;

        // Reset state
        step(); step();
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_valid", {31'd0, dataValid}, 32'd0);
        check("rst_bcd", {20'd0, bcdOut}, 32'd0);
        check("rst_sel", {29'd0, digitSel}, 32'b001);
        check("rst_seg", {25'd0, seg}, 32'd0);
        check("rst_ca_sel", {29'd0, caDigitSel}, 32'b110);
        check("rst_ca_seg", {25'd0, caSeg}, 32'h7f);
        rst = 1'b1;
        step(); step();
        check("idle_busy", {31'd0, busy}, 32'd0);

        // 255 -> 0x255, busy exactly 8 cycles
        startLoad(8'd255, 1'b1, 12'h255);
        step();
        load = 1'b0;
        check("b255_busy_e0", {31'd0, busy}, 32'd1);
        runSteps(6, 1'b1, "b255_busy");
        step();   // E7
        check("b255_busy_e7", {31'd0, busy}, 32'd1);
        check("b255_notyet", {31'd0, dataValid}, 32'd0);
        check("b255_bcd_hidden", {20'd0, bcdOut}, 32'd0);
        step();   // E8
        check("b255_busy_end", {31'd0, busy}, 32'd0);
        popCheck("b255_bcd");
        step(); step();
        checkDigit(3'b001, 7'b1101101, "b255_ones");
        waitSel(3'b010, "b255_tens_arrive", found);
        if (found) begin
            check("b255_tens", {25'd0, seg}, 32'b1101101);
            n = 0;
            while (digitSel === 3'b010 && n < 20) begin
                step();
                n++;
            end
            check("b255_hold", n, RD);
        end
        checkDigit(3'b100, 7'b1011011, "b255_hund");

        // 0 -> ones 0, others blank
        startLoad(8'd0, 1'b1, 12'h000);
        step(); load = 1'b0;
        runSteps(7, 1'b1, "z_busy");
        step();
        popCheck("z_bcd");
        step(); step();
        checkDigit(3'b001, 7'b0111111, "z_ones");
        checkDigit(3'b010, 7'b0000000, "z_tens");
        checkDigit(3'b100, 7'b0000000, "z_hund");

        // 9
        startLoad(8'd9, 1'b1, 12'h009);
        step(); load = 1'b0;
        runSteps(7, 1'b1, "n9_busy");
        step();
        popCheck("n9_bcd");
        step(); step();
        checkDigit(3'b001, 7'b1101111, "n9_ones");
        checkDigit(3'b010, 7'b0000000, "n9_tens");
        checkDigit(3'b100, 7'b0000000, "n9_hund");

        // 40
        startLoad(8'd40, 1'b1, 12'h040);
        step(); load = 1'b0;
        runSteps(7, 1'b1, "n40_busy");
        step();
        popCheck("n40_bcd");
        step(); step();
        checkDigit(3'b001, 7'b0111111, "n40_ones");
        checkDigit(3'b010, 7'b1100110, "n40_tens");
        checkDigit(3'b100, 7'b0000000, "n40_hund");

        // Back-to-back: 200 @E0, 7 @E3 (overwritten), 99 @E5
        startLoad(8'd200, 1'b1, 12'h200);
        step(); load = 1'b0;                       // E0
        runSteps(2, 1'b1, "bb_busy_a");            // E1,E2
        startLoad(8'd7, 1'b0, 12'h000);
        runSteps(1, 1'b1, "bb_busy_b");            // E3
        load = 1'b0;
        runSteps(1, 1'b1, "bb_busy_c");            // E4
        startLoad(8'd99, 1'b1, 12'h099);
        runSteps(1, 1'b1, "bb_busy_d");            // E5
        load = 1'b0;
        runSteps(3, 1'b1, "bb_busy_e");            // E6..E8
        popCheck("bb_200");
        runSteps(7, 1'b1, "bb_busy_f");            // E9..E15
        step();                                    // E16
        popCheck("bb_099");
        check("bb_busy_end", {31'd0, busy}, 32'd0);
        runSteps(3, 1'b0, "bb_idle");

        // Completion-edge collision: 13 @E0, 250 @E8
        startLoad(8'd13, 1'b1, 12'h013);
        step(); load = 1'b0;
        runSteps(7, 1'b1, "col_busy_a");           // E1..E7
        startLoad(8'd250, 1'b1, 12'h250);
        step(); load = 1'b0;                       // E8
        popCheck("col_013");
        check("col_nogap", {31'd0, busy}, 32'd1);
        runSteps(7, 1'b1, "col_busy_b");           // E9..E15
        step();                                    // E16
        popCheck("col_250");
        check("col_busy_end", {31'd0, busy}, 32'd0);

        // Reset mid-conversion with a pending value
        startLoad(8'd123, 1'b0, 12'h000);
        step(); load = 1'b0;                       // E0
        runSteps(1, 1'b1, "mr_busy");              // E1
        startLoad(8'd77, 1'b0, 12'h000);
        step(); load = 1'b0;                       // E2 (pending)
        step();                                    // E3
        rst = 1'b0;
        #1;
        check("mr_busy0", {31'd0, busy}, 32'd0);
        check("mr_valid0", {31'd0, dataValid}, 32'd0);
        check("mr_bcd0", {20'd0, bcdOut}, 32'd0);
        check("mr_sel0", {29'd0, digitSel}, 32'b001);
        check("mr_seg0", {25'd0, seg}, 32'd0);
        step(); step();
        rst = 1'b1;
        runSteps(12, 1'b0, "mr_idle");
        check("mr_no_result", {20'd0, bcdOut}, 32'd0);
        check("mr_no_valid", {31'd0, dataValid}, 32'd0);
        startLoad(8'd45, 1'b1, 12'h045);
        step(); load = 1'b0;
        runSteps(7, 1'b1, "mr45_busy");
        step();
        popCheck("mr_045");
        check("mr45_busy_end", {31'd0, busy}, 32'd0);
        check("queue_drained", expQ.size(), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
